// File: rtl/dot_accum.sv
// -----------------------------------------------------------------------------
// dot_accum
// Accumulates the per-chunk partial sums coming out of a registered adder tree
// into one dot-product result. A chunk is "issued" when in_valid and in_ready
// are both high. A LAT-deep valid pipe tracks the chunk through the tree so
// that the matching tree_dout is added exactly LAT cycles later. When every
// issued chunk has been received, the result is held on out_data with
// out_valid until the consumer accepts it.
//
// Build option:
//   DOT_ACCUM_SAT_EN  defined   -> an overflowing add clamps acc to all ones
//                     undefined -> acc wraps modulo 2^ACC_W
//   ovf is a sticky carry-out flag in both builds.
//
// Parameters:
//   IN_W   width of tree_dout
//   NUM    input count of the feeding tree; tree latency LAT = $clog2(NUM)
//   ACC_W  accumulator / result width (ACC_W >= IN_W)
//   CNT_W  chunk-count width
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      one-cycle request to begin (honoured only in IDLE)
//   len        number of chunks, sampled with start
//   in_valid   chunk operands enter the tree this cycle
//   in_ready   a chunk may be issued this cycle
//   tree_dout  registered adder-tree output (unsigned)
//   out_valid  result held on out_data
//   out_ready  consumer accept
//   out_data   accumulated sum (equals acc in every state)
//   ovf        sticky overflow flag for the current result
//   busy       FSM not in IDLE
// -----------------------------------------------------------------------------
module dot_accum #(
  parameter int IN_W  = 16,
  parameter int NUM   = 256,
  parameter int ACC_W = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  tree_dout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             ovf,
  output logic             busy
);

  // A single-input tree still has one register stage.
  localparam int LAT = (NUM > 1) ? $clog2(NUM) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [CNT_W-1:0] len_r, len_s;
  logic [CNT_W-1:0] issued_r, issued_s;
  logic [CNT_W-1:0] received_r, received_s;
  logic [ACC_W-1:0] acc_r, acc_s;
  logic             ovf_r, ovf_s;
  logic [LAT-1:0]   vpipe_r, vpipe_s;
  logic             in_ready_r, in_ready_s;
  logic             out_valid_r, out_valid_s;
  logic             busy_r, busy_s;

  logic             accept_s;
  logic             pipe_out_s;
  logic [ACC_W:0]   sum_s;

  // Next-state, datapath and next-output computation.
  always_comb begin
    state_s    = state_r;
    len_s      = len_r;
    issued_s   = issued_r;
    received_s = received_r;
    acc_s      = acc_r;
    ovf_s      = ovf_r;

    // in_ready_r already encodes "ACCUM and issued < len" for this cycle,
    // so a not-ready in_valid can never enter the valid pipe.
    accept_s   = in_valid & in_ready_r;
    pipe_out_s = vpipe_r[LAT-1];
    vpipe_s    = LAT'({vpipe_r, accept_s});
    sum_s      = {1'b0, acc_r} + {{(ACC_W + 1 - IN_W){1'b0}}, tree_dout};

    case (state_r)
      IDLE: begin
        if (start) begin
          len_s      = len;
          issued_s   = {CNT_W{1'b0}};
          received_s = {CNT_W{1'b0}};
          acc_s      = {ACC_W{1'b0}};
          ovf_s      = 1'b0;
          if (len != {CNT_W{1'b0}}) begin
            state_s = ACCUM;
          end else begin
            state_s = DONE;
          end
        end else begin
          state_s = IDLE;
        end
      end

      ACCUM: begin
        if (accept_s) begin
          issued_s = issued_r + CNT_W'(1'b1);
        end else begin
          issued_s = issued_r;
        end
        if (pipe_out_s) begin
          received_s = received_r + CNT_W'(1'b1);
          if (sum_s[ACC_W]) begin
            ovf_s = 1'b1;
`ifdef DOT_ACCUM_SAT_EN
            acc_s = {ACC_W{1'b1}};
`else
            acc_s = sum_s[ACC_W-1:0];
`endif
          end else begin
            acc_s = sum_s[ACC_W-1:0];
          end
          // Last chunk lands this cycle: result is visible next cycle.
          if ((received_r + CNT_W'(1'b1)) == len_r) begin
            state_s = DONE;
          end else begin
            state_s = ACCUM;
          end
        end else begin
          state_s = ACCUM;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end

      default: begin
        state_s = IDLE;
      end
    endcase

    // Outputs are registered, so they are derived from the next state.
    in_ready_s  = (state_s == ACCUM) && (issued_s < len_s);
    out_valid_s = (state_s == DONE);
    busy_s      = (state_s != IDLE);
  end

  // State, datapath and output registers; reset discards in-flight chunks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      len_r       <= {CNT_W{1'b0}};
      issued_r    <= {CNT_W{1'b0}};
      received_r  <= {CNT_W{1'b0}};
      acc_r       <= {ACC_W{1'b0}};
      ovf_r       <= 1'b0;
      vpipe_r     <= {LAT{1'b0}};
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      len_r       <= len_s;
      issued_r    <= issued_s;
      received_r  <= received_s;
      acc_r       <= acc_s;
      ovf_r       <= ovf_s;
      vpipe_r     <= vpipe_s;
      in_ready_r  <= in_ready_s;
      out_valid_r <= out_valid_s;
      busy_r      <= busy_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = acc_r;
  assign ovf       = ovf_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_dot_accum.sv
// -----------------------------------------------------------------------------
// tb_dot_accum
// Scoreboard bench for dot_accum with NUM=4 (LAT=2), IN_W=ACC_W=8, CNT_W=8.
// A two-stage register model of the adder tree feeds tree_dout. Expected
// results ({ovf, data}) are queued when a dot product is started; a monitor
// on the falling edge pops and compares on every out_valid & out_ready.
// -----------------------------------------------------------------------------
module tb_dot_accum;

  localparam int IN_W  = 8;
  localparam int NUM   = 4;
  localparam int ACC_W = 8;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  tree_dout;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic             ovf;
  logic             busy;

  logic [IN_W-1:0]  chunk;
  logic [IN_W-1:0]  tp0, tp1;

  logic [ACC_W:0]   exp_q[$];
  int               n_cmp = 0;
  int               n_err = 0;

  dot_accum #(
    .IN_W (IN_W),
    .NUM  (NUM),
    .ACC_W(ACC_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .len      (len),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .tree_dout(tree_dout),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .ovf      (ovf),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Adder-tree model: two register stages, not reset, so stale partial
  // sums keep flowing across a DUT reset.
  always @(posedge clk) begin
    tp0 <= chunk;
    tp1 <= tp0;
  end
  assign tree_dout = tp1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: compare each accepted result against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        logic [ACC_W:0] e;
        e = exp_q.pop_front();
        check("sb_data", {24'd0, out_data}, {24'd0, e[ACC_W-1:0]});
        check("sb_ovf", {31'd0, ovf}, {31'd0, e[ACC_W]});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [IN_W-1:0] v);
    in_valid = 1'b1;
    chunk    = v;
    tick();
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    chunk    = 8'hAA;
  endtask

  task automatic begin_op(input logic [CNT_W-1:0] n, input logic [ACC_W:0] e);
    exp_q.push_back(e);
    start = 1'b1;
    len   = n;
    tick();
    start = 1'b0;
    len   = 8'd0;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check(name, {31'd0, out_valid}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ACC_W:0] ovf_exp;
    int acc_cnt;

    rst_n     = 1'b0;
    start     = 1'b0;
    len       = 8'd0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chunk     = 8'hAA;
    tick();
    tick();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Back-to-back 5,7,9: start in cycle 0, out_valid in cycle 6.
    begin_op(8'd3, {1'b0, 8'd21});
    check("accum_in_ready", {31'd0, in_ready}, 32'd1);
    check("accum_busy", {31'd0, busy}, 32'd1);
    issue(8'd5);
    issue(8'd7);
    issue(8'd9);
    idle_in();
    check("lat_c4", {31'd0, out_valid}, 32'd0);
    tick();
    check("lat_c5", {31'd0, out_valid}, 32'd0);
    tick();
    check("lat_c6", {31'd0, out_valid}, 32'd1);
    tick();
    check("idle_after_b2b", {31'd0, busy}, 32'd0);

    // len == 0 goes straight to DONE.
    begin_op(8'd0, {1'b0, 8'd0});
    check("len0_valid", {31'd0, out_valid}, 32'd1);
    check("len0_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    check("len0_idle", {31'd0, busy}, 32'd0);

    // Chunks with gaps: 17 + 34 + 51.
    begin_op(8'd3, {1'b0, 8'd102});
    issue(8'd17);
    idle_in();
    tick();
    issue(8'd34);
    idle_in();
    tick();
    issue(8'd51);
    idle_in();
    wait_valid("gap_valid");
    tick();

    // Overflow: 200 + 100 exceeds 8 bits.
`ifdef DOT_ACCUM_SAT_EN
    ovf_exp = {1'b1, 8'd255};
`else
    ovf_exp = {1'b1, 8'd44};
`endif
    begin_op(8'd2, ovf_exp);
    issue(8'd200);
    issue(8'd100);
    idle_in();
    wait_valid("ovf_valid");
    tick();

    // Held result with out_ready low; start in DONE is ignored.
    out_ready = 1'b0;
    begin_op(8'd2, {1'b0, 8'd30});
    issue(8'd10);
    issue(8'd20);
    idle_in();
    wait_valid("hold_valid");
    for (int i = 0; i < 10; i++) begin
      check("hold_out_valid", {31'd0, out_valid}, 32'd1);
      check("hold_out_data", {24'd0, out_data}, 32'd30);
      if (i == 3) begin
        start = 1'b1;
        len   = 8'd5;
      end else begin
        start = 1'b0;
        len   = 8'd0;
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("accept_idle_busy", {31'd0, busy}, 32'd0);
    check("accept_idle_valid", {31'd0, out_valid}, 32'd0);
    tick();
    check("start_in_done_ignored", {31'd0, busy}, 32'd0);

    // Reset after 2 of 4 chunks; stale tree outputs must not be added.
    start = 1'b1;
    len   = 8'd4;
    tick();
    start = 1'b0;
    issue(8'd50);
    issue(8'd60);
    idle_in();
    rst_n = 1'b0;
    #2;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_out_data", {24'd0, out_data}, 32'd0);
    check("mid_rst_ovf", {31'd0, ovf}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b1;
    begin_op(8'd1, {1'b0, 8'd3});
    issue(8'd3);
    idle_in();
    wait_valid("post_rst_valid");
    tick();

    // in_valid held for 6 cycles with len=4: only the first 4 count.
    begin_op(8'd4, {1'b0, 8'd10});
    acc_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      chunk    = (i < 4) ? 8'(i + 1) : 8'(50 + i);
      if (in_ready) acc_cnt++;
      tick();
    end
    idle_in();
    check("accept_count", acc_cnt, 32'd4);
    check("ready_low_after", {31'd0, in_ready}, 32'd0);
    wait_valid("hold6_valid");
    tick();
    tick();

    check("sb_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dot_accum.md
DOT_ACCUM -- requirements
Module: dot_accum

Interface
REQ-001 SHALL have parameter IN_W, default 16, meaning the width of the adder-tree result (SIZE+$clog2(NUM) of the feeding tree).
REQ-002 SHALL have parameter NUM, default 256, meaning the feeding tree's input count; it sets the tree latency LAT=$clog2(NUM).
REQ-003 SHALL have parameter ACC_W, default 32, meaning the accumulator and result width; ACC_W>=IN_W.
REQ-004 SHALL have parameter CNT_W, default 16, meaning the chunk-count width.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-007 SHALL have port start, input, 1, a one-cycle request to begin a dot product.
REQ-008 SHALL have port len, input, CNT_W, the number of chunks, sampled with start.
REQ-009 SHALL have port in_valid, input, 1, asserted in the same cycle the chunk operands enter the tree.
REQ-010 SHALL have port in_ready, output, 1, indicating that a chunk may be issued this cycle.
REQ-011 SHALL have port tree_dout, input, IN_W, the registered adder-tree output, unsigned.
REQ-012 SHALL have port out_valid, output, 1, indicating that the result is held.
REQ-013 SHALL have port out_ready, input, 1, the consumer accept.
REQ-014 SHALL have port out_data, output, ACC_W, the dot-product sum.
REQ-015 SHALL have port ovf, output, 1, a sticky overflow flag for the current result.
REQ-016 SHALL have port busy, output, 1, high when state!=IDLE.

Function
REQ-017 SHALL implement states IDLE, ACCUM and DONE.
REQ-018 IDLE: start with len!=0 SHALL latch len, clear acc, issued count, received count and ovf, and go to ACCUM.
REQ-019 IDLE: start with len==0 SHALL go directly to DONE with out_data=0 and ovf=0.
REQ-020 start SHALL be ignored outside IDLE.
REQ-021 in_ready SHALL be 1 iff state==ACCUM and issued<len.
REQ-022 in_valid while in_ready=0 SHALL be ignored and SHALL never enter the valid pipe.
REQ-023 An accepted issue (in_valid&in_ready) SHALL increment issued and push 1 into a LAT-deep valid shift pipe; otherwise 0 is pushed.
REQ-024 Valid-pipe alignment: a chunk issued in cycle c SHALL have its pipe output high in cycle c+LAT, coincident with its tree_dout.
REQ-025 A high pipe output in ACCUM SHALL cause acc<=acc+zero-extended tree_dout and received+1 at the end of that cycle.
REQ-026 When received reaches len, the state SHALL be DONE in the next cycle; latency is out_valid in cycle c_last+LAT+1.
REQ-027 DONE SHALL drive out_valid=1 with out_data=acc held stable until out_valid&out_ready, then go to IDLE in the next cycle.
REQ-028 out_data SHALL equal acc in all states; out_valid SHALL be 0 outside DONE.
REQ-029 Back-to-back issue, one chunk per cycle, SHALL be supported without bubbles.
REQ-030 An accumulate carry-out beyond ACC_W bits SHALL set ovf, which is sticky until the next start.

Reset
REQ-031 rst_n low SHALL asynchronously force IDLE and clear acc, the counters, the valid pipe and ovf.
REQ-032 Reset values SHALL be out_valid=0, out_data=0, ovf=0, busy=0 and in_ready=0.
REQ-033 Reset mid-ACCUM SHALL discard in-flight chunks; tree outputs arriving after reset release SHALL NOT be accumulated.

Configuration
REQ-034 With macro DOT_ACCUM_SAT_EN defined, an overflowing add SHALL clamp acc to 2^ACC_W-1, after which acc stays clamped.
REQ-035 With DOT_ACCUM_SAT_EN undefined, acc SHALL wrap modulo 2^ACC_W.
REQ-036 ovf SHALL behave identically in both builds.

Verification
REQ-037 NUM=4 (LAT=2), start len=3, chunks 5,7,9 issued back-to-back from cycle 1 -> out_valid in cycle 6, out_data=21, ovf=0.
REQ-038 start len=0 -> out_valid next cycle, out_data=0, in_ready stays 0.
REQ-039 DONE with out_ready=0 for 10 cycles, then 1 -> out_data stable throughout, IDLE one cycle after accept, and start during DONE ignored.
REQ-040 ACC_W=IN_W=8, chunks 200,100 -> without macro out_data=44, ovf=1; with DOT_ACCUM_SAT_EN out_data=255, ovf=1.
REQ-041 rst_n low after 2 of 4 chunks issued -> outputs reset; a new start len=1 with chunk 3 -> out_data=3 (no stale adds).
REQ-042 in_valid held high for 6 cycles with len=4 -> exactly 4 accepted, in_ready low thereafter, and the sum covers only the first 4.
